// File: rtl/game_tick_ctrl.sv
// Game-state controller and difficulty-scaled tick divider for the game-tick path.
// Ticks are issued only in RUN; the divider period shrinks by SPEED_STEP every PIPES_PER_LEVEL pipes.
module game_tick_ctrl #(
  parameter int unsigned SPEED_INIT      = 2_499_999,
  parameter int unsigned SPEED_STEP      = 250_000,
  parameter int unsigned SPEED_MIN       = 999_999,
  parameter int unsigned PIPES_PER_LEVEL = 5,
  parameter int unsigned LEVEL_MAX       = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        pipe_passed,
  input  logic        collision,
  output logic        tick,
  output logic [26:0] speed,
  output logic [3:0]  level,
  output logic [9:0]  score,
  output logic [1:0]  state
);

  localparam int PCNT_W = (PIPES_PER_LEVEL > 1) ? $clog2(PIPES_PER_LEVEL) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PIPES_PER_LEVEL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [26:0]        cnt_q, cnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [26:0]        speed_d;
  logic [3:0]         level_d;
  logic [9:0]         score_d;
  logic               tick_d;

  // Compare at 28 bits so SPEED_MIN + SPEED_STEP cannot overflow and speed cannot underflow.
  function automatic logic [26:0] speed_step_down(input logic [26:0] s);
    logic [27:0] knee;
    knee = 28'(SPEED_MIN) + 28'(SPEED_STEP);
    if ({1'b0, s} < knee) return 27'(SPEED_MIN);
    return s - 27'(SPEED_STEP);
  endfunction

  function automatic logic [3:0] level_sat_inc(input logic [3:0] l);
    if (l >= 4'(LEVEL_MAX)) return 4'(LEVEL_MAX);
    return l + 4'd1;
  endfunction

  function automatic logic [9:0] score_sat_inc(input logic [9:0] s);
    if (s == 10'd1023) return s;
    return s + 10'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    speed_d = speed;
    level_d = level;
    score_d = score;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        cnt_d = '0;
        if (start) begin
          state_d = RUN;
          speed_d = 27'(SPEED_INIT);
          level_d = '0;
          score_d = '0;
          pcnt_d  = '0;
        end
      end
      RUN: begin
        // The divider runs on every RUN cycle, including the one that leaves RUN.
        if (cnt_q >= speed) begin
          cnt_d  = '0;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 27'd1;
        end
        if (collision) begin
          state_d = OVER;
        end else begin
          if (pipe_passed) begin
            score_d = score_sat_inc(score);
            if (pcnt_q == PCNT_LAST) begin
              pcnt_d  = '0;
              level_d = level_sat_inc(level);
              speed_d = speed_step_down(speed);
            end else begin
              pcnt_d = pcnt_q + PCNT_W'(1);
            end
          end
          if (pause) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pcnt_q <= '0;
      speed  <= 27'(SPEED_INIT);
      level  <= '0;
      score  <= '0;
      tick   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pcnt_q <= pcnt_d;
      speed  <= speed_d;
      level  <= level_d;
      score  <= score_d;
      tick   <= tick_d;
    end
  end

  assign state = state_q;

endmodule
